iob_vga_timing: RTL
===================

Name: iob_vga_timing

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock.
- Drives the pixel coordinate bus (pixel_x, pixel_y) consumed by the image memory.
- Samples the 12-bit colour returned by the image memory and registers it, aligned with hsync/vsync, onto the VGA pins.
- Sits between the image memory RGB output and the board VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal values are 1 and above

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  timing enable; when low, all state freezes
- test_pattern  in  1  colour-bar override request (see Optional Feature)
- rgb_in  in  12  colour for the current pixel_x/pixel_y, combinational from the image memory
- pixel_x  out  10  current column while active, 0 otherwise
- pixel_y  out  10  current row while active, 0 otherwise
- pixel_active  out  1  high while h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
- frame_start  out  1  one-clk pulse at the frame wrap
- vga_hsync  out  1  registered, negative polarity
- vga_vsync  out  1  registered, negative polarity
- vga_rgb  out  12  registered colour, forced to 0 during blanking

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counters: h_cnt and v_cnt are 10 bits wide. Elaboration fails if H_TOTAL or V_TOTAL exceeds 1024.
- Pixel tick divider:
  - div_cnt counts 0..CLK_DIV-1, advancing only when en=1.
  - tick = en && div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, tick=en every cycle.
- Raster counters, advanced on tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
- Combinational outputs from counter state:
  - pixel_active as defined in Ports.
  - pixel_x = h_cnt and pixel_y = v_cnt when active, else both 0.
- Sync windows (counter domain):
  - hs_n = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_n = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output stage, updated on tick only:
  - vga_hsync <= hs_n; vga_vsync <= vs_n.
  - vga_rgb <= pixel_active ? colour : 0, where colour is rgb_in (or the test pattern).
  - Latency is exactly one pixel tick from counter state to pins; sync and colour stay mutually aligned.
- frame_start:
  - Registered pulse, high for exactly one clk.
  - Asserted in the cycle after the tick on which the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- en low:
  - div_cnt, h_cnt, v_cnt and all registered outputs hold; frame_start = 0.
  - Resuming continues from the held position with no skipped pixel.
- Reset, asserted at any time, takes effect immediately:
  - div_cnt = h_cnt = v_cnt = 0.
  - vga_hsync = 1, vga_vsync = 1, vga_rgb = 0, frame_start = 0.
  - Consequently pixel_x = 0, pixel_y = 0, pixel_active = 1.
  - After deassertion the first tick occurs CLK_DIV cycles later.
- rgb_in is sampled only when pixel_active=1; its value in blanking is don't-care.

Optional Feature:
- Macro: IOB_VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - When test_pattern=1, colour = 8 vertical bars, bar b = pixel_x / (H_ACTIVE/8), b = 0..7.
  - colour = {{4{b[2]}},{4{b[1]}},{4{b[0]}}}; bar 0 is black, bar 7 is white (0xFFF).
  - The division is implemented as a compare chain, not a divider.
- Not defined:
  - test_pattern is ignored and colour = rgb_in always.
  - No pattern logic is present.

Test Plan:
- Reset, then 2 frames with defaults and en=1 -> hsync low for 96*4=384 clk every 3200 clk; vsync low for 2 lines (6400 clk) every 1,680,000 clk; frame_start pulses exactly once per frame.
- rgb_in = {pixel_x[3:0], pixel_y[3:0], 4'hA} -> on the tick after counters reach (5,3), vga_rgb = 0x53A; during h_cnt 640..799 vga_rgb = 0.
- CLK_DIV=1, small params (H 8/1/2/1, V 4/1/1/1) -> h_cnt wraps after 12 clk; vsync low on line 5; pixel_x sequence 0..7 then 0.
- en low for 50 clk mid-line at h_cnt=100 -> pixel_x holds 100, outputs frozen, no frame_start; after release pixel_x reaches 101 after CLK_DIV clk.
- rst asserted mid-frame at (300,200) -> same cycle pixel_x=0, vga_hsync=1, vga_vsync=1, vga_rgb=0; after release, timing restarts from (0,0).
- Macro defined, test_pattern=1, rgb_in=0 -> pixel_x=0 gives 0x000, pixel_x=80 gives 0x00F, pixel_x=639 gives 0xFFF; test_pattern=0 gives rgb_in.

Source files
------------

// File: rtl/iob_vga_timing.sv
// Purpose: 640x480@60 VGA raster timing, pixel coordinate bus and registered RGB/sync pins.
// Latency: one pixel tick from counter state to vga_hsync/vga_vsync/vga_rgb; frame_start one clk after the wrap tick.
// Backpressure: none; en=0 freezes all state in place, resuming with no skipped pixel.
// Optional colour-bar generator: define IOB_VGA_TIMING_TEST_PATTERN_EN.
module iob_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        test_pattern,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_active,
    output logic        frame_start,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [11:0] vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-domain constants are 11 bits so a window edge of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Elaboration guards: raster must fit 10-bit counters, divider must be at least 1.
    generate
        if (H_TOTAL > 1024) begin : g_bad_h_total
            $error("iob_vga_timing: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("iob_vga_timing: V_TOTAL exceeds 1024");
        end
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("iob_vga_timing: CLK_DIV must be 1 or more");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             frame_start_q, frame_start_d;

    logic        tick;
    logic        h_end;
    logic        v_end;
    logic        active;
    logic        hs_n;
    logic        vs_n;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic [11:0] colour;

    // Pixel tick divider: advances only while enabled, tick on its last count.
    always_comb begin
        tick      = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        if (en) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Raster counters: horizontal wraps into vertical, vertical wraps at frame end.
    always_comb begin
        h_end   = (h_cnt_q == H_LAST);
        v_end   = (v_cnt_q == V_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_end) begin
                h_cnt_d = '0;
                v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Visible-area decode, coordinate bus and negative sync windows from current counter state.
    always_comb begin
        h_ext        = {1'b0, h_cnt_q};
        v_ext        = {1'b0, v_cnt_q};
        active       = (h_ext < H_ACT_L) && (v_ext < V_ACT_L);
        pixel_active = active;
        pixel_x      = active ? h_cnt_q : '0;
        pixel_y      = active ? v_cnt_q : '0;
        hs_n         = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_n         = !((v_ext >= VS_START) && (v_ext < VS_END));
    end

`ifdef IOB_VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [10:0] px_ext;

    // Colour source: eight vertical bars picked by a threshold chain on pixel_x, else image memory.
    always_comb begin
        px_ext = {1'b0, pixel_x};
        bar    = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (px_ext >= 11'(b * BAR_W)) begin
                bar = 3'(b);
            end
        end
        colour = test_pattern ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : rgb_in;
    end
`else
    logic unused_test_pattern;

    // Colour source: image memory only; the override request has no effect in this build.
    always_comb begin
        unused_test_pattern = test_pattern;
        colour              = rgb_in;
    end
`endif

    // Output stage: sync and blanked colour captured together on the tick; frame pulse on the wrap tick.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = tick && h_end && v_end;
        if (tick) begin
            hsync_d = hs_n;
            vsync_d = vs_n;
            rgb_d   = active ? colour : 12'h000;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 12'h000;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_rgb     = rgb_q;
    assign frame_start = frame_start_q;

endmodule
